// File: rtl/instr_mem.sv
// Instruction memory: registered fetch port plus a reload FSM that clears the
// array to HALT_WORD and then streams in a new program over a valid/ready link.
module instr_mem #(
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       DEPTH     = 256,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(16'h0800)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_en,
  input  logic              f_flush,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_instr,
  output logic              f_valid,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic              ld_last,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic [ADDR_W:0]   ld_count
);

  localparam int unsigned     CNT_W   = ADDR_W + 1;
  localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   clr_ptr, clr_ptr_d, count_d;
  logic               ready_d, busy_d, we, accept;
  logic [IDX_W-1:0]   waddr;
  logic [DATA_W-1:0]  wdata;
  logic [DATA_W-1:0]  mem [DEPTH];

  // Next-state, write-port and next-output logic for the load FSM
  always_comb begin
    state_d   = state;
    clr_ptr_d = clr_ptr;
    count_d   = ld_count;
    we        = 1'b0;
    accept    = 1'b0;
    waddr     = '0;
    wdata     = ld_data;
    case (state)
      IDLE: begin
        if (ld_start) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
          count_d   = '0;
        end
      end
      CLEAR: begin
        we        = 1'b1;
        waddr     = IDX_W'(clr_ptr);
        wdata     = HALT_WORD;
        clr_ptr_d = clr_ptr + CNT_W'(1);
        if (clr_ptr == LAST_C) state_d = LOAD;
      end
      LOAD: begin
        accept = ld_valid && ld_ready && (ld_count != DEPTH_C);
        if (accept) begin
          we      = 1'b1;
          waddr   = IDX_W'(ld_count);
          count_d = ld_count + CNT_W'(1);
          if (ld_last || (count_d == DEPTH_C)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == LOAD) && (count_d != DEPTH_C);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      clr_ptr  <= '0;
      ld_count <= '0;
      ld_ready <= 1'b0;
      ld_busy  <= 1'b0;
    end else begin
      state    <= state_d;
      clr_ptr  <= clr_ptr_d;
      ld_count <= count_d;
      ld_ready <= ready_d;
      ld_busy  <= busy_d;
    end
  end

  // Single write port shared by clear and load; contents are never reset
  always_ff @(posedge clock) begin
    if (we && !reset) mem[waddr] <= wdata;
  end

  // Registered fetch; a busy loader hides the partially written program
  always_ff @(posedge clock) begin
    if (reset || f_flush || ld_busy) begin
      f_instr <= HALT_WORD;
      f_valid <= 1'b0;
    end else if (f_en) begin
      f_valid <= 1'b1;
      if ({1'b0, f_addr} >= DEPTH_C) f_instr <= HALT_WORD;
      else                           f_instr <= mem[IDX_W'(f_addr)];
    end
  end

endmodule

// File: tb/tb_instr_mem.sv
// Directed bench for instr_mem: reset, clear/load, stall/flush, overflow,
// reset-abort and out-of-range fetch on a DEPTH=128 instance.
module tb_instr_mem;

  logic        clock;
  logic        reset;
  logic        f_en, f_flush;
  logic [7:0]  f_addr;
  logic        ld_start, ld_valid, ld_last;
  logic [15:0] ld_data;

  logic [15:0] a_instr, b_instr;
  logic        a_valid, b_valid, a_ready, b_ready, a_busy, b_busy;
  logic [8:0]  a_count, b_count;

  int checks = 0;
  int errors = 0;

  instr_mem dut_a (
    .clock(clock), .reset(reset), .f_en(f_en), .f_flush(f_flush), .f_addr(f_addr),
    .f_instr(a_instr), .f_valid(a_valid), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_last(ld_last), .ld_data(ld_data), .ld_ready(a_ready), .ld_busy(a_busy),
    .ld_count(a_count)
  );

  instr_mem #(.ADDR_W(8), .DATA_W(16), .DEPTH(128), .HALT_WORD(16'h0800)) dut_b (
    .clock(clock), .reset(reset), .f_en(f_en), .f_flush(f_flush), .f_addr(f_addr),
    .f_instr(b_instr), .f_valid(b_valid), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_last(ld_last), .ld_data(ld_data), .ld_ready(b_ready), .ld_busy(b_busy),
    .ld_count(b_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fetch(input logic [7:0] addr, input logic [15:0] exp);
    f_en   = 1'b1;
    f_addr = addr;
    tick();
    chk("fetch_instr", 32'(a_instr), 32'(exp));
    chk("fetch_valid", 32'(a_valid), 32'd1);
  endtask

  task automatic run_clear();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i == 0) chk("clear_fvalid", 32'(a_valid), 32'd0);
      if (i < 255 && (i % 64 == 0)) begin
        chk("clear_busy", 32'(a_busy), 32'd1);
        chk("clear_ready", 32'(a_ready), 32'd0);
      end
    end
    chk("load_ready", 32'(a_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; f_en = 1'b1; f_flush = 1'b0; f_addr = 8'd0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 16'h0;
    tick(); tick();
    chk("rst_fvalid", 32'(a_valid), 32'd0);
    chk("rst_finstr", 32'(a_instr), 32'h0800);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_count", 32'(a_count), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_fvalid", 32'(a_valid), 32'd1);

    // Clear then load three words; a stray ld_start mid-clear must not restart it
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i == 10) ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      if (i == 0) chk("clear_fvalid", 32'(a_valid), 32'd0);
      if (i < 255 && (i % 64 == 0)) begin
        chk("clear_busy", 32'(a_busy), 32'd1);
        chk("clear_ready", 32'(a_ready), 32'd0);
      end
    end
    chk("load_ready", 32'(a_ready), 32'd1);
    ld_valid = 1'b1; ld_data = 16'h1234; tick();
    ld_data = 16'h5678; tick();
    ld_data = 16'h9ABC; ld_last = 1'b1; tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("done_count", 32'(a_count), 32'd3);
    chk("done_ready", 32'(a_ready), 32'd0);
    chk("done_busy", 32'(a_busy), 32'd1);
    tick();
    chk("idle_busy", 32'(a_busy), 32'd0);
    chk("idle_count", 32'(a_count), 32'd3);
    fetch(8'd0, 16'h1234);
    fetch(8'd1, 16'h5678);
    fetch(8'd2, 16'h9ABC);
    fetch(8'd3, 16'h0800);

    // Stall holds the word while the address moves; flush beats fetch
    fetch(8'd0, 16'h1234);
    f_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      f_addr = 8'(i);
      tick();
      chk("stall_instr", 32'(a_instr), 32'h1234);
      chk("stall_valid", 32'(a_valid), 32'd1);
    end
    f_en = 1'b1; f_flush = 1'b1; f_addr = 8'd1;
    tick();
    f_flush = 1'b0;
    chk("flush_instr", 32'(a_instr), 32'h0800);
    chk("flush_valid", 32'(a_valid), 32'd0);

    // Offer 257 words without ld_last; only 256 fit
    run_clear();
    for (int k = 0; k <= 256; k++) begin
      ld_valid = 1'b1;
      ld_data  = 16'h4000 | 16'(k);
      if (k == 256) chk("ovf_ready_257", 32'(a_ready), 32'd0);
      tick();
      if (k == 255) begin
        chk("ovf_done_busy", 32'(a_busy), 32'd1);
        chk("ovf_count", 32'(a_count), 32'd256);
      end
    end
    ld_valid = 1'b0;
    chk("ovf_idle_busy", 32'(a_busy), 32'd0);
    chk("ovf_idle_count", 32'(a_count), 32'd256);
    fetch(8'd255, 16'h40FF);
    fetch(8'd0, 16'h4000);

    // Reset while word 2 is offered aborts the load
    run_clear();
    ld_valid = 1'b1; ld_data = 16'hC000; tick();
    ld_data = 16'hC001; tick();
    ld_data = 16'hC002; reset = 1'b1; tick();
    chk("abort_busy", 32'(a_busy), 32'd0);
    chk("abort_count", 32'(a_count), 32'd0);
    chk("abort_ready", 32'(a_ready), 32'd0);
    chk("abort_finstr", 32'(a_instr), 32'h0800);
    reset = 1'b0; ld_valid = 1'b0;
    fetch(8'd0, 16'hC000);
    fetch(8'd1, 16'hC001);
    fetch(8'd2, 16'h0800);
    fetch(8'd3, 16'h0800);

    // Out-of-range fetch on the DEPTH=128 instance
    f_en = 1'b1; f_addr = 8'd200;
    tick();
    chk("oor_instr", 32'(b_instr), 32'h0800);
    chk("oor_valid", 32'(b_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
